// File: rtl/rtc_gen_counter_pkg.sv
// Shared types and width-parametrised constants for the counter bank.
package rtc_gen_counter_pkg;

    typedef enum logic {
        WRAP     = 1'b0,
        SATURATE = 1'b1
    } lane_mode_t;

    // Returned 64 bits wide; callers size-cast to their own lane width.
    function automatic logic [63:0] lane_max(int unsigned w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] lane_one(int unsigned w);
        return (w > 0) ? 64'd1 : 64'd0;
    endfunction

    function automatic logic [63:0] lane_zero(int unsigned w);
        return lane_max(w) & ~lane_max(w);
    endfunction

endpackage

// File: rtl/rtc_gen_counter_lane.sv
// One up/down counter lane: load > incr^decr > hold, wrap or saturate on overflow.
// Latency 1 cycle; clken low freezes every register, including the ovf pulse.
module rtc_gen_counter_lane
    import rtc_gen_counter_pkg::*;
#(
    parameter int                 C_WIDTH      = 8,
    parameter int                 C_STEP_WIDTH = 4,
    parameter logic [C_WIDTH-1:0] C_INIT       = '0,
    parameter lane_mode_t         C_MODE       = WRAP
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clken,
    input  logic                    load,
    input  logic                    incr,
    input  logic                    decr,
    input  logic [C_STEP_WIDTH-1:0] step,
    input  logic [C_WIDTH-1:0]      load_value,
    input  logic                    clr_sticky,
    output logic [C_WIDTH-1:0]      count,
    output logic                    is_zero,
    output logic                    is_max,
    output logic                    ovf,
    output logic                    ovf_sticky
);

    localparam logic [C_WIDTH-1:0] MAX  = C_WIDTH'(lane_max(C_WIDTH));
    localparam logic [C_WIDTH-1:0] ZERO = C_WIDTH'(lane_zero(C_WIDTH));

    logic [C_WIDTH:0]   step_ext;
    logic [C_WIDTH:0]   sum;
    logic [C_WIDTH:0]   diff;
    logic [C_WIDTH-1:0] count_nxt;
    logic               ovf_nxt;
    logic               sticky_nxt;

    // One extra bit holds the carry (incr) or borrow (decr).
    assign step_ext = {{(C_WIDTH + 1 - C_STEP_WIDTH){1'b0}}, step};
    assign sum      = {1'b0, count} + step_ext;
    assign diff     = {1'b0, count} - step_ext;

    always_comb begin
        count_nxt = count;
        ovf_nxt   = 1'b0;
        if (load) begin
            count_nxt = load_value;
        end else if ((incr ^ decr) && (step != '0)) begin
            if (incr) begin
                ovf_nxt   = sum[C_WIDTH];
                count_nxt = (sum[C_WIDTH] && (C_MODE == SATURATE)) ? MAX : sum[C_WIDTH-1:0];
            end else begin
                ovf_nxt   = diff[C_WIDTH];
                count_nxt = (diff[C_WIDTH] && (C_MODE == SATURATE)) ? ZERO : diff[C_WIDTH-1:0];
            end
        end
    end

    assign sticky_nxt = ovf_nxt | (ovf_sticky & ~clr_sticky);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= C_INIT;
            is_zero    <= (C_INIT == ZERO);
            is_max     <= (C_INIT == MAX);
            ovf        <= 1'b0;
            ovf_sticky <= 1'b0;
        end else if (clken) begin
            count      <= count_nxt;
            is_zero    <= (count_nxt == ZERO);
            is_max     <= (count_nxt == MAX);
            ovf        <= ovf_nxt;
            ovf_sticky <= sticky_nxt;
        end
    end

endmodule

// File: rtl/rtc_gen_counter_bank.sv
// Bank of C_CHANNELS independent counter lanes over flattened per-lane vectors.
// Latency 1 cycle; no backpressure, clken is the only global stall.
module rtc_gen_counter_bank
    import rtc_gen_counter_pkg::*;
#(
    parameter int                    C_CHANNELS   = 4,
    parameter int                    C_WIDTH      = 8,
    parameter int                    C_STEP_WIDTH = 4,
    parameter logic [C_WIDTH-1:0]    C_INIT       = '0,
    parameter logic [C_CHANNELS-1:0] C_SATURATE   = '0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               clken,
    input  logic [C_CHANNELS-1:0]              load,
    input  logic [C_CHANNELS-1:0]              incr,
    input  logic [C_CHANNELS-1:0]              decr,
    input  logic [C_CHANNELS*C_STEP_WIDTH-1:0] step,
    input  logic [C_CHANNELS*C_WIDTH-1:0]      load_value,
    input  logic [C_CHANNELS-1:0]              clr_sticky,
    output logic [C_CHANNELS*C_WIDTH-1:0]      count,
    output logic [C_CHANNELS-1:0]              is_zero,
    output logic [C_CHANNELS-1:0]              is_max,
    output logic [C_CHANNELS-1:0]              ovf,
    output logic [C_CHANNELS-1:0]              ovf_sticky
);

    for (genvar i = 0; i < C_CHANNELS; i++) begin : g_lane
        rtc_gen_counter_lane #(
            .C_WIDTH      (C_WIDTH),
            .C_STEP_WIDTH (C_STEP_WIDTH),
            .C_INIT       (C_INIT),
            .C_MODE       (C_SATURATE[i] ? SATURATE : WRAP)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .clken      (clken),
            .load       (load[i]),
            .incr       (incr[i]),
            .decr       (decr[i]),
            .step       (step[i*C_STEP_WIDTH +: C_STEP_WIDTH]),
            .load_value (load_value[i*C_WIDTH +: C_WIDTH]),
            .clr_sticky (clr_sticky[i]),
            .count      (count[i*C_WIDTH +: C_WIDTH]),
            .is_zero    (is_zero[i]),
            .is_max     (is_max[i]),
            .ovf        (ovf[i]),
            .ovf_sticky (ovf_sticky[i])
        );
    end

endmodule
